lane_scheduler: RTL and testbench

Schedules the three falling-byte lanes of the FlippyBit game while the top-level game state machine is in its play state. Generates the shared fall-speed tick, scaled by the current score, and issues one-cycle spawn pulses with a pseudo-random target byte. Free lanes are granted round-robin, with a minimum gap between spawns. Sits between the game state machine (which supplies `score` and `enable`) and the three lane datapaths (which report `lane_busy`).

---
 rtl/lane_scheduler.sv | 167 ++++++++++++++++
 tb/tb_lane_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lane_scheduler.sv
// lane_scheduler: paces the falling-byte lanes during play. Produces the
// score-scaled fall tick, and grants free lanes round-robin with a pseudo-random
// nonzero target byte. Consecutive grants are separated by a minimum number of
// fall ticks.
module lane_scheduler #(
  parameter int BASE_PERIOD = 16,
  parameter int STEP        = 2,
  parameter int MIN_PERIOD  = 4,
  parameter int SPAWN_GAP   = 4
) (
  input  logic       clock,
  input  logic       reset_button,
  input  logic       enable,
  input  logic [7:0] score,
  input  logic [2:0] lane_busy,
  output logic [2:0] spawn,
  output logic [7:0] target,
  output logic       fall_tick,
  output logic [3:0] level,
  output logic [1:0] sched_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SPAWN = 2'd2
  } state_t;

  localparam logic [3:0]  GAP_INIT    = 4'(SPAWN_GAP);
  localparam logic [15:0] PERIOD_INIT = 16'(BASE_PERIOD);
  localparam logic [7:0]  LFSR_SEED   = 8'hA5;

  state_t      r_state;
  logic [2:0]  r_spawn;
  logic [7:0]  r_target;
  logic        r_fall_tick;
  logic [3:0]  r_level;
  logic [7:0]  r_lfsr;
  logic [1:0]  r_last_grant;
  logic [15:0] r_tick;
  logic [15:0] r_period;
  logic [3:0]  r_gap;

  logic [1:0]  w_cand1;
  logic [1:0]  w_cand2;
  logic [1:0]  w_cand3;
  logic [1:0]  w_grant;
  logic [2:0]  w_grant_oh;
  logic        w_free;
  logic [7:0]  w_lfsr_next;
  logic        w_wrap;

  // Period for a given level, clamped at MIN_PERIOD. Worked in 20 bits so a
  // large STEP*level can never wrap below zero.
  function automatic logic [15:0] f_period(input logic [3:0] lvl);
    logic [19:0] w_base;
    logic [19:0] w_dec;
    logic [19:0] w_min;
    logic [19:0] w_diff;
    w_base = 20'(BASE_PERIOD);
    w_min  = 20'(MIN_PERIOD);
    w_dec  = 20'(STEP) * {16'd0, lvl};
    w_diff = w_base - w_dec;
    if ((w_dec >= w_base) || (w_diff < w_min)) begin
      return w_min[15:0];
    end
    return w_diff[15:0];
  endfunction

  // Gap count saturates at 15 so a long blocked stretch cannot wrap it.
  function automatic logic [3:0] f_gap_inc(input logic [3:0] g);
    return (g == 4'd15) ? 4'd15 : g + 4'd1;
  endfunction

  // Next lane index modulo 3.
  function automatic logic [1:0] f_next_lane(input logic [1:0] l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] l);
    return 3'b001 << l;
  endfunction

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_wrap      = (r_tick == (r_period - 16'd1));

  // Round-robin search starting just after the last granted lane.
  always_comb begin
    w_cand1    = f_next_lane(r_last_grant);
    w_cand2    = f_next_lane(w_cand1);
    w_cand3    = f_next_lane(w_cand2);
    w_grant    = 2'd0;
    w_grant_oh = 3'b000;
    w_free     = 1'b0;
    if ((lane_busy & f_onehot(w_cand1)) == 3'b000) begin
      w_grant = w_cand1;
      w_free  = 1'b1;
    end else if ((lane_busy & f_onehot(w_cand2)) == 3'b000) begin
      w_grant = w_cand2;
      w_free  = 1'b1;
    end else if ((lane_busy & f_onehot(w_cand3)) == 3'b000) begin
      w_grant = w_cand3;
      w_free  = 1'b1;
    end
    w_grant_oh = f_onehot(w_grant);
  end

  // Scheduler state, fall-tick timing, spawn grant and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_button) begin
      r_state      <= S_IDLE;
      r_spawn      <= 3'b000;
      r_target     <= 8'h00;
      r_fall_tick  <= 1'b0;
      r_level      <= 4'd0;
      r_lfsr       <= LFSR_SEED;
      r_last_grant <= 2'd2;
      r_tick       <= 16'd0;
      r_period     <= PERIOD_INIT;
      r_gap        <= GAP_INIT;
    end else begin
      r_level     <= score[7:4];
      r_spawn     <= 3'b000;
      r_fall_tick <= 1'b0;
      if (!enable) begin
        // Leaving play: LFSR and last_grant survive so play resumes the sequence.
        r_state <= S_IDLE;
        r_tick  <= 16'd0;
        r_gap   <= GAP_INIT;
      end else begin
        if (r_state != S_IDLE) begin
          if (w_wrap) begin
            // Period only reloads here, so a level change never cuts a step short.
            r_tick      <= 16'd0;
            r_fall_tick <= 1'b1;
            r_period    <= f_period(r_level);
            r_gap       <= f_gap_inc(r_gap);
          end else begin
            r_tick <= r_tick + 16'd1;
          end
        end
        case (r_state)
          S_IDLE:  r_state <= S_WAIT;
          S_WAIT: begin
            if ((r_gap >= GAP_INIT) && w_free) begin
              r_state      <= S_SPAWN;
              r_spawn      <= w_grant_oh;
              r_target     <= r_lfsr;
              r_last_grant <= w_grant;
              r_lfsr       <= w_lfsr_next;
              r_gap        <= 4'd0;
            end
          end
          S_SPAWN: r_state <= S_WAIT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign spawn       = r_spawn;
  assign target      = r_target;
  assign fall_tick   = r_fall_tick;
  assign level       = r_level;
  assign sched_state = r_state;

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler with hand-computed expectations.
module tb_lane_scheduler;

  logic       clock = 1'b0;
  logic       reset_button;
  logic       enable;
  logic [7:0] score;
  logic [2:0] lane_busy;
  logic [2:0] spawn;
  logic [7:0] target;
  logic       fall_tick;
  logic [3:0] level;
  logic [1:0] sched_state;

  int n_cmp  = 0;
  int n_fail = 0;

  lane_scheduler #(
    .BASE_PERIOD(16),
    .STEP(2),
    .MIN_PERIOD(4),
    .SPAWN_GAP(4)
  ) dut (
    .clock(clock),
    .reset_button(reset_button),
    .enable(enable),
    .score(score),
    .lane_busy(lane_busy),
    .spawn(spawn),
    .target(target),
    .fall_tick(fall_tick),
    .level(level),
    .sched_state(sched_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Clocks until the next fall_tick pulse; -1 on timeout.
  task automatic wait_tick(output int n);
    bit seen;
    seen = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (fall_tick === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) n = -1;
  endtask

  // Clocks until the next spawn; counts fall ticks seen on the way.
  task automatic wait_spawn(output int ticks, output bit found);
    ticks = 0;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (fall_tick === 1'b1) ticks++;
      if (spawn !== 3'b000) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  tk;
    bit  found;
    int  n_sp;
    int  n_ft;

    // Reset held with enable high: everything at zero, IDLE.
    reset_button = 1'b0;
    enable       = 1'b1;
    score        = 8'h00;
    lane_busy    = 3'b000;
    repeat (3) step();
    chk("rst_spawn", spawn, 3'b000);
    chk("rst_target", target, 8'h00);
    chk("rst_fall", fall_tick, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_state", sched_state, 2'd0);

    // Release: WAIT after first edge, spawn on lane 0 with A5 after the second.
    reset_button = 1'b1;
    step();
    chk("rel1_state", sched_state, 2'd1);
    chk("rel1_spawn", spawn, 3'b000);
    step();
    chk("rel2_spawn", spawn, 3'b001);
    chk("rel2_target", target, 8'hA5);
    chk("rel2_state", sched_state, 2'd2);
    step();
    chk("rel3_spawn", spawn, 3'b000);
    chk("rel3_state", sched_state, 2'd1);

    // Round-robin with all lanes free, 4 fall ticks between spawns.
    wait_spawn(tk, found);
    chk("rr1_found", found, 1);
    chk("rr1_spawn", spawn, 3'b010);
    chk("rr1_target", target, 8'h4A);
    chk("rr1_ticks", tk, 4);
    step();
    chk("rr1_gap", spawn, 3'b000);
    wait_spawn(tk, found);
    chk("rr2_spawn", spawn, 3'b100);
    chk("rr2_target", target, 8'h95);
    chk("rr2_ticks", tk, 4);
    wait_spawn(tk, found);
    chk("rr3_spawn", spawn, 3'b001);
    chk("rr3_target", target, 8'h2A);
    chk("rr3_ticks", tk, 4);

    // Tick scaling; lanes held busy so no spawns disturb the LFSR.
    lane_busy = 3'b111;
    wait_tick(n);
    chk("t0_seen", (n > 0), 1);
    wait_tick(n);
    chk("t0_period", n, 16);
    score = 8'h30;
    wait_tick(n);
    chk("t3_inflight", n, 16);
    wait_tick(n);
    chk("t3_period", n, 10);
    chk("t3_level", level, 4'd3);
    score = 8'h70;
    wait_tick(n);
    chk("t7_inflight", n, 10);
    wait_tick(n);
    chk("t7_period", n, 4);
    chk("t7_level", level, 4'd7);
    score = 8'hF0;
    wait_tick(n);
    chk("tf_inflight", n, 4);
    wait_tick(n);
    chk("tf_period", n, 4);
    chk("tf_level", level, 4'd15);

    // All lanes busy for 10 ticks: no spawn, stays in WAIT.
    n_sp = 0;
    n_ft = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (spawn !== 3'b000) n_sp++;
      if (fall_tick === 1'b1) n_ft++;
      if (n_ft == 10) break;
    end
    chk("blk_ticks", n_ft, 10);
    chk("blk_spawns", n_sp, 0);
    chk("blk_state", sched_state, 2'd1);
    lane_busy = 3'b101;
    step();
    chk("blk_free_spawn", spawn, 3'b010);
    chk("blk_free_target", target, 8'h54);
    chk("blk_free_state", sched_state, 2'd2);
    step();
    chk("blk_after", spawn, 3'b000);

    // Mid-operation disable, then re-enable.
    lane_busy = 3'b000;
    enable = 1'b0;
    step();
    chk("dis_state", sched_state, 2'd0);
    chk("dis_spawn", spawn, 3'b000);
    chk("dis_fall", fall_tick, 1'b0);
    n_sp = 0;
    n_ft = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (spawn !== 3'b000) n_sp++;
      if (fall_tick !== 1'b0) n_ft++;
    end
    chk("dis_quiet", n_sp + n_ft, 0);
    chk("dis_hold_state", sched_state, 2'd0);
    enable = 1'b1;
    step();
    chk("ren1_state", sched_state, 2'd1);
    chk("ren1_spawn", spawn, 3'b000);
    step();
    chk("ren2_spawn", spawn, 3'b100);
    chk("ren2_target", target, 8'hA9);

    // Enable drops on the edge a spawn would register: suppressed, LFSR kept.
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    chk("sim_wait", sched_state, 2'd1);
    enable = 1'b0;
    step();
    chk("sim_spawn", spawn, 3'b000);
    chk("sim_state", sched_state, 2'd0);
    enable = 1'b1;
    step();
    step();
    chk("sim_resume_spawn", spawn, 3'b001);
    chk("sim_resume_target", target, 8'h53);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
